// File: rtl/gray_code_counter_if.sv
// Control and count bundle for gray_code_counter: the master drives the
// step/load controls, the slave (the counter) returns binary, Gray and wrap.
interface gray_code_counter_if #(
    parameter int WIDTH = 4
);
    // Control semantics (no valid/ready pair): en requests one step per clk,
    // up picks the direction, load overrides en, and every output is registered.
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] g;
    logic             wrap;

    modport master (
        output en, up, load, load_val,
        input  b, g, wrap
    );

    modport slave (
        input  en, up, load, load_val,
        output b, g, wrap
    );
endinterface

// File: rtl/gray_code_counter.sv
// Registered up/down binary counter with a Gray-coded copy and a wrap pulse.
// WIDTH is meant to stay within 2..16; g is always the Gray form of b.
module gray_code_counter #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    gray_code_counter_if.slave     bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] g_q;
    logic             wrap_q;

    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] g_next;
    logic             wrap_next;

    // MSB passes through; every lower bit is the XOR of itself and its upper neighbour.
    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] bin);
        logic [WIDTH-1:0] gray;
        gray[WIDTH-1] = bin[WIDTH-1];
        for (int i = 0; i < WIDTH - 1; i++) begin
            gray[i] = bin[i+1] ^ bin[i];
        end
        return gray;
    endfunction

    always_comb begin
        b_next    = b_q;
        wrap_next = 1'b0;
        if (bus.load) begin
            b_next = bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                b_next    = b_q + ONE;
                wrap_next = (b_q == ALL_ONES);
            end else begin
                b_next    = b_q - ONE;
                wrap_next = (b_q == '0);
            end
        end
    end

    // Gray is derived from the next binary value so b and g land on the same edge.
    assign g_next = bin_to_gray(b_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q    <= '0;
            g_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            b_q    <= b_next;
            g_q    <= g_next;
            wrap_q <= wrap_next;
        end
    end

    assign bus.b    = b_q;
    assign bus.g    = g_q;
    assign bus.wrap = wrap_q;
endmodule

// File: doc/gray_code_counter.md
# gray_code_counter

Registered up/down counter that keeps a binary count and drives its Gray-code equivalent, one bit change per step. It produces the Gray sequence that the existing 4-bit Gray-to-binary converter decodes, so the two can be paired in benches and in pointer paths. Typical use: Gray-coded position or pointer source, with the decoder on the consuming side.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  count enable; one step per clk while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when stepping.
- load  input  1  synchronous load of load_val; overrides en.
- load_val  input  WIDTH  binary value to load.
- b  output  WIDTH  registered binary count.
- g  output  WIDTH  registered Gray count; always equals b ^ (b >> 1).
- wrap  output  1  one-cycle pulse on the clock after the count wraps.

## Operation
- Reset: b = 0, g = 0, wrap = 0. All outputs are forced immediately, without waiting for clk, and held while rst is high.
- Priority at each rising clk, highest first: rst, then load, then en, then hold.
- load = 1:
  - b <= load_val and g <= load_val ^ (load_val >> 1).
  - wrap <= 0. en and up are ignored.
- en = 1, load = 0:
  - up = 1: b <= b + 1, modulo 2^WIDTH.
  - up = 0: b <= b - 1, modulo 2^WIDTH.
  - g is updated in the same edge from the next b value, not from the current b. b and g never disagree on any cycle.
- en = 0, load = 0: b and g hold; wrap <= 0.
- Gray rule, MSB first:
  - g[WIDTH-1] = b[WIDTH-1].
  - g[i] = b[i+1] ^ b[i] for i < WIDTH-1.
- Wrap detection, evaluated only on an en step:
  - wrap <= 1 when up = 1 and b = 2^WIDTH-1, so the next b is 0.
  - wrap <= 1 when up = 0 and b = 0, so the next b is 2^WIDTH-1.
  - Otherwise wrap <= 0.
- Single-bit invariant: across any en step, including wrap, exactly one bit of g changes. A load may change several bits; this is allowed.
- A direction change between steps is legal. The count reverses on the next step with no idle cycle.

## Timing
- Latency: one clk from an en or load sample to the new b and g.
- No combinational path from any input to any output; all outputs come straight from flops.
- wrap is high for exactly one cycle, the cycle in which the wrapped value is presented.
- Throughput: one step per clk when en is held high.
- Reset mid-count:
  - Asserting rst clears b, g and wrap asynchronously, including a wrap pulse in flight.
  - On the first rising clk after rst deasserts, load and en are honored normally.
- load and en high together: load wins and no step occurs.
- Loading the current value is legal: g is unchanged and wrap = 0.

## Test plan
- Reset then count up (WIDTH=4):
  - Stimulus: rst pulse, then en=1, up=1 for 16 clks.
  - Required: g runs 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000.
  - Required: wrap = 1 only in the cycle g returns to 0000.
  - Required: feeding g through the existing Gray-to-binary converter reproduces b on every cycle.
- Count down through zero:
  - Stimulus: after reset, en=1, up=0 for one clk.
  - Required: b=1111, g=1000, wrap=1 for one cycle.
  - Required: the next step down gives b=1110, g=1001, wrap=0.
- Load priority:
  - Stimulus: load=1, en=1, load_val=1011.
  - Required: b=1011, g=1110, wrap=0.
  - Then en=1, up=1 for one clk: required b=1100, g=1010.
- Hold and direction change:
  - Stimulus: at b=0101, en=0 for 3 clks.
  - Required: g stays 0111.
  - Then en=1 with up=1, 0, 0 on successive clks: required b = 0110, 0101, 0100.
- Async reset mid-operation:
  - Stimulus: b=0111, rst asserted between clk edges.
  - Required: b=0, g=0, wrap=0 before the next edge.
  - Required: the first step after release gives b=0001.
- Invariant check (randomized en, up, load over 10,000 cycles):
  - Required: g == b ^ (b >> 1) on every cycle.
  - Required: the Hamming distance between successive g values is exactly 1 on every en step.
